// File: rtl/parity_checker.sv
// -----------------------------------------------------------------------------
// parity_checker
//
// Receive end of a parity-protected link. Each incoming word arrives with a
// parity bit over a valid/ready handshake. The checker recomputes parity,
// tags the word with an error bit and forwards it through a 2-entry FIFO.
// The first pop is possible one cycle after the accept. A saturating error
// counter and a sticky error flag are kept for status readout.
//
// Parameters
//   DATA_WIDTH    width of the data word covered by the parity bit
//   ODD_PARITY    0: even parity (parity = ^data), 1: odd parity (parity = ~^data)
//   ERR_CNT_WIDTH width of the saturating error counter
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_in_data      received data word
//   i_in_parity    received parity bit
//   i_in_valid     source has a word
//   o_in_ready     checker can accept (FIFO not full)
//   o_out_data     head-of-FIFO data (0 while empty)
//   o_out_err      head word failed the parity check
//   o_out_valid    FIFO not empty
//   i_out_ready    sink accepts the head word
//   i_err_clr      synchronous clear of error counter and sticky flag
//   o_err_cnt      number of parity errors seen, saturating
//   o_err_sticky   set on any error, held until i_err_clr
//
// Build option
//   PARITY_CHECKER_DROP_EN  when defined, bad words are counted but not
//                           written into the FIFO, and o_out_err is tied to 0.
// -----------------------------------------------------------------------------
module parity_checker #(
    parameter int DATA_WIDTH    = 8,
    parameter bit ODD_PARITY    = 1'b0,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [DATA_WIDTH-1:0]    i_in_data,
    input  logic                     i_in_parity,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic [DATA_WIDTH-1:0]    o_out_data,
    output logic                     o_out_err,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    input  logic                     i_err_clr,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
    output logic                     o_err_sticky
);

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_ONE = ERR_CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0]    r_memData [2];
    logic                     r_wrPtr;
    logic                     r_rdPtr;
    logic [1:0]               r_count;
    logic [ERR_CNT_WIDTH-1:0] r_errCnt;
    logic                     r_errSticky;

    logic w_bad;
    logic w_accept;
    logic w_pop;
    logic w_write;

    // Parity of data XOR received parity bit is 0 for a correct even-parity
    // word and 1 for a correct odd-parity word.
    assign w_bad    = ((^i_in_data) ^ i_in_parity) != ODD_PARITY;

    // Ready and valid come from the registered count only, so the sink's
    // ready never reaches the source's ready combinationally.
    assign o_in_ready  = (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);

    assign w_accept = i_in_valid & o_in_ready;
    assign w_pop    = o_out_valid & i_out_ready;

    assign o_out_data = o_out_valid ? r_memData[r_rdPtr] : '0;

`ifdef PARITY_CHECKER_DROP_EN
    assign w_write   = w_accept & ~w_bad;
    assign o_out_err = 1'b0;
`else
    logic [1:0] r_memErr;

    assign w_write   = w_accept;
    assign o_out_err = o_out_valid ? r_memErr[r_rdPtr] : 1'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_memErr <= '0;
        end else if (w_write) begin
            r_memErr[r_wrPtr] <= w_bad;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_memData[0] <= '0;
            r_memData[1] <= '0;
        end else if (w_write) begin
            r_memData[r_wrPtr] <= i_in_data;
        end
    end

    // Pointers are one bit and simply toggle, which wraps 1 -> 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_write) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear takes effect before counting, so a clear coinciding with a bad
    // accept leaves the counter at one and the sticky flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_errCnt    <= '0;
            r_errSticky <= 1'b0;
        end else begin
            if (w_accept && w_bad) begin
                r_errSticky <= 1'b1;
                if (i_err_clr) begin
                    r_errCnt <= ERR_CNT_ONE;
                end else if (r_errCnt != ERR_CNT_MAX) begin
                    r_errCnt <= r_errCnt + ERR_CNT_ONE;
                end
            end else if (i_err_clr) begin
                r_errCnt    <= '0;
                r_errSticky <= 1'b0;
            end
        end
    end

    assign o_err_cnt    = r_errCnt;
    assign o_err_sticky = r_errSticky;

endmodule

// File: tb/tb_parity_checker.sv
// -----------------------------------------------------------------------------
// tb_parity_checker
//
// Drives three parity_checker instances with the same inputs:
//   dut0  default configuration (even parity, 8-bit counter)
//   dut1  ERR_CNT_WIDTH = 2 (exercises saturation)
//   dut2  ODD_PARITY = 1
// A queue-based reference model per instance predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_parity_checker;

`ifdef PARITY_CHECKER_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstN;
    logic [7:0] inData;
    logic       inParity;
    logic       inValid;
    logic       outReady;
    logic       errClr;

    logic       rdy0, rdy1, rdy2;
    logic       vld0, vld1, vld2;
    logic [7:0] data0, data1, data2;
    logic       err0, err1, err2;
    logic [7:0] cnt0, cnt2;
    logic [1:0] cnt1;
    logic       stk0, stk1, stk2;

    int compCount = 0;
    int failCount = 0;

    typedef logic [8:0] entry_t;
    entry_t mq0[$];
    entry_t mq1[$];
    entry_t mq2[$];
    int     mCnt[3];
    bit     mSticky[3];
    int     cntMax[3] = '{255, 3, 255};
    bit     oddCfg[3] = '{1'b0, 1'b0, 1'b1};

    typedef struct {
        logic [7:0] data;
        logic       parity;
        bit         badEven;
        bit         badOdd;
    } vector_t;

    vector_t vecs[8];

    always #5 clk = ~clk;

    parity_checker dut0 (
        .i_clk(clk), .i_rst_n(rstN), .i_in_data(inData), .i_in_parity(inParity),
        .i_in_valid(inValid), .o_in_ready(rdy0), .o_out_data(data0), .o_out_err(err0),
        .o_out_valid(vld0), .i_out_ready(outReady), .i_err_clr(errClr),
        .o_err_cnt(cnt0), .o_err_sticky(stk0)
    );

    parity_checker #(.ERR_CNT_WIDTH(2)) dut1 (
        .i_clk(clk), .i_rst_n(rstN), .i_in_data(inData), .i_in_parity(inParity),
        .i_in_valid(inValid), .o_in_ready(rdy1), .o_out_data(data1), .o_out_err(err1),
        .o_out_valid(vld1), .i_out_ready(outReady), .i_err_clr(errClr),
        .o_err_cnt(cnt1), .o_err_sticky(stk1)
    );

    parity_checker #(.ODD_PARITY(1'b1)) dut2 (
        .i_clk(clk), .i_rst_n(rstN), .i_in_data(inData), .i_in_parity(inParity),
        .i_in_valid(inValid), .o_in_ready(rdy2), .o_out_data(data2), .o_out_err(err2),
        .o_out_valid(vld2), .i_out_ready(outReady), .i_err_clr(errClr),
        .o_err_cnt(cnt2), .o_err_sticky(stk2)
    );

    // A word is bad when the total number of ones (data plus parity bit) does
    // not have the parity the link promises: even count for even parity.
    function automatic bit isBad(logic [7:0] d, logic p, bit odd);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) != int'(odd);
    endfunction

    function automatic int qSize(int k);
        case (k)
            0:       return mq0.size();
            1:       return mq1.size();
            default: return mq2.size();
        endcase
    endfunction

    function automatic entry_t qHead(int k);
        case (k)
            0:       return mq0[0];
            1:       return mq1[0];
            default: return mq2[0];
        endcase
    endfunction

    task automatic qPush(int k, entry_t e);
        case (k)
            0:       mq0.push_back(e);
            1:       mq1.push_back(e);
            default: mq2.push_back(e);
        endcase
    endtask

    task automatic qPop(int k);
        entry_t dummy;
        case (k)
            0:       dummy = mq0.pop_front();
            1:       dummy = mq1.pop_front();
            default: dummy = mq2.pop_front();
        endcase
    endtask

    task automatic modelReset();
        mq0.delete();
        mq1.delete();
        mq2.delete();
        for (int k = 0; k < 3; k++) begin
            mCnt[k]    = 0;
            mSticky[k] = 1'b0;
        end
    endtask

    // Advance every model by one clock edge using the inputs held before it.
    task automatic modelEdge();
        for (int k = 0; k < 3; k++) begin
            bit accept;
            bit pop;
            bit bad;
            accept = inValid && (qSize(k) < 2);
            pop    = (qSize(k) > 0) && outReady;
            bad    = isBad(inData, inParity, oddCfg[k]);
            if (pop) qPop(k);
            if (accept && !(DROP && bad)) qPush(k, {(DROP ? 1'b0 : bad), inData});
            if (errClr) begin
                mCnt[k]    = 0;
                mSticky[k] = 1'b0;
            end
            if (accept && bad) begin
                if (mCnt[k] < cntMax[k]) mCnt[k] = mCnt[k] + 1;
                mSticky[k] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(string name, int actual, int expected);
        compCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic getActual(int k, output int rdy, output int vld, output int dat,
                             output int err, output int cnt, output int stk);
        case (k)
            0: begin rdy = int'(rdy0); vld = int'(vld0); dat = int'(data0);
                     err = int'(err0); cnt = int'(cnt0); stk = int'(stk0); end
            1: begin rdy = int'(rdy1); vld = int'(vld1); dat = int'(data1);
                     err = int'(err1); cnt = int'(cnt1); stk = int'(stk1); end
            default: begin rdy = int'(rdy2); vld = int'(vld2); dat = int'(data2);
                     err = int'(err2); cnt = int'(cnt2); stk = int'(stk2); end
        endcase
    endtask

    task automatic checkAll();
        for (int k = 0; k < 3; k++) begin
            int rdy, vld, dat, err, cnt, stk;
            int expDat, expErr;
            entry_t head;
            getActual(k, rdy, vld, dat, err, cnt, stk);
            expDat = 0;
            expErr = 0;
            if (qSize(k) > 0) begin
                head   = qHead(k);
                expDat = int'(head[7:0]);
                expErr = int'(head[8]);
            end
            checkOutput($sformatf("dut%0d in_ready", k), rdy, int'(qSize(k) < 2));
            checkOutput($sformatf("dut%0d out_valid", k), vld, int'(qSize(k) > 0));
            checkOutput($sformatf("dut%0d out_data", k), dat, expDat);
            checkOutput($sformatf("dut%0d out_err", k), err, expErr);
            checkOutput($sformatf("dut%0d err_cnt", k), cnt, mCnt[k]);
            checkOutput($sformatf("dut%0d err_sticky", k), stk, int'(mSticky[k]));
        end
    endtask

    task automatic applyStimulus(logic v, logic [7:0] d, logic p, logic oRdy, logic clr);
        inValid  = v;
        inData   = d;
        inParity = p;
        outReady = oRdy;
        errClr   = clr;
    endtask

    // Called one time unit after a rising edge; checks, then crosses one edge.
    task automatic stepCycle();
        #1;
        checkAll();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic drain();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        stepCycle();
        stepCycle();
        stepCycle();
    endtask

    task automatic doReset();
        #1;
        rstN = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] popped[$];
        logic [7:0] wantOrder[3];
        bit         acceptedNow;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        wantOrder[0] = 8'h11;
        wantOrder[1] = 8'h22;
        wantOrder[2] = 8'h33;

        $display("[TB] start, drop mode = %0d", DROP);
        rstN = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset in_ready", int'(rdy0), 1);
        checkOutput("reset out_valid", int'(vld0), 0);
        checkOutput("reset err_cnt", int'(cnt0), 0);
        checkOutput("reset err_sticky", int'(stk0), 0);
        checkAll();
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Single words through an empty FIFO, checked against the table.
        foreach (vecs[i]) begin
            drain();
            applyStimulus(1'b1, vecs[i].data, vecs[i].parity, 1'b1, 1'b0);
            stepCycle();
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d even valid", i), int'(vld0),
                        int'(!(DROP && vecs[i].badEven)));
            if (vld0) begin
                checkOutput($sformatf("vec%0d even data", i), int'(data0), int'(vecs[i].data));
                checkOutput($sformatf("vec%0d even err", i), int'(err0),
                            int'(!DROP && vecs[i].badEven));
            end
            checkOutput($sformatf("vec%0d odd valid", i), int'(vld2),
                        int'(!(DROP && vecs[i].badOdd)));
            if (vld2) begin
                checkOutput($sformatf("vec%0d odd err", i), int'(err2),
                            int'(!DROP && vecs[i].badOdd));
            end
            stepCycle();
        end

        // Backpressure: two words fill the FIFO, the third is held at source.
        drain();
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("bp in_ready low", int'(rdy0), 0);
        stepCycle();
        checkOutput("bp in_ready still low", int'(rdy0), 0);
        outReady = 1'b1;
        for (int n = 0; n < 8; n++) begin
            #1;
            acceptedNow = inValid && rdy0;
            if (vld0) popped.push_back(data0);
            stepCycle();
            if (acceptedNow) inValid = 1'b0;
        end
        checkOutput("bp pop count", popped.size(), 3);
        for (int n = 0; n < 3 && n < popped.size(); n++) begin
            checkOutput($sformatf("bp order %0d", n), int'(popped[n]), int'(wantOrder[n]));
        end

        // Saturation on the 2-bit counter, then clear coinciding with a bad word.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        stepCycle();
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("sat err_cnt w2", int'(cnt1), 3);
        checkOutput("sat err_cnt w8", int'(cnt0), 5);
        checkOutput("sat sticky", int'(stk1), 1);
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        stepCycle();
        checkOutput("clr+bad err_cnt w2", int'(cnt1), 1);
        checkOutput("clr+bad err_cnt w8", int'(cnt0), 1);
        checkOutput("clr+bad sticky", int'(stk0), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        stepCycle();
        checkOutput("clr err_cnt", int'(cnt1), 0);
        checkOutput("clr sticky", int'(stk1), 0);

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) doReset();
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 19) == 0));
            stepCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", compCount, failCount);
        $finish;
    end

endmodule
